craft_round_core: RTL and testbench
===================================

Name: craft_round_core

Overview:
- Iterative CRAFT-64 encryption datapath. Executes one round per clock.
- Sits directly downstream of craft_key_schedule: drives that block's round index and consumes its 64-bit round tweakey TK combinationally in the same cycle.
- Plaintext is accepted via a valid/ready handshake. Ciphertext is held under a valid/ready handshake until the consumer takes it.

Parameters:
- NR, 32: number of rounds, legal range 1..32. The final round always omits PN and SB. Values below 32 are for reduced-round verification only.

Ports:
- CLK100MHZ  input  1  system clock.
- CPU_RESET  input  1  asynchronous, active-high reset.
- pt_i  input  64  plaintext. Nibble I0 = [63:60] ... I15 = [3:0].
- in_valid_i  input  1  plaintext valid.
- in_ready_o  output  1  core can accept plaintext.
- round_o  output  8  round index to key schedule r input.
- tk_i  input  64  round tweakey from key schedule for round_o, same cycle.
- ct_o  output  64  ciphertext.
- out_valid_o  output  1  ct_o valid.
- out_ready_i  input  1  consumer accepts ct_o.

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset puts the FSM in IDLE.
- Reset values: state reg = 0, ct_o = 0, out_valid_o = 0, round_o = 0, a = 4'h1, b = 3'h1. in_ready_o = 1 during and after reset.
- in_ready_o = 1 only in IDLE. out_valid_o = 1 only in DONE. round_o = 0 outside RUN.
- IDLE: on in_valid_i & in_ready_o: load S <= pt_i, rnd <= 0, a <= 1, b <= 1, go to RUN. in_valid_i without acceptance has no effect.
- RUN, each cycle with round_o = rnd:
  - MC per column i = 0..3: I_i ^= I_{i+8} ^ I_{i+12}; I_{i+4} ^= I_{i+12}. All right-hand sides use pre-MC values.
  - ARC: I4 ^= a; I5 ^= {1'b0, b}.
  - ATK: S ^= tk_i.
  - If rnd < NR-1: PN, then SB.
    - PN: nibble I_i moves to position P(i), with P = [15,12,13,14,10,9,8,11,6,5,4,7,1,2,3,0] (an involution).
    - SB on every nibble: S = [C,A,D,3,E,B,F,7,8,9,1,5,0,2,4,6].
    - Then rnd++, and step both LFSRs:
      - a <= {a0^a1, a[3:1]}, giving the sequence 1,8,4,2,9,C,6,B,5,A,D,E,F,7,3,1...
      - b <= {b0^b1, b[2:1]}, giving the sequence 1,4,2,5,6,7,3,1...
  - If rnd == NR-1: ct_o <= post-ATK value, round_o <= 0, go to DONE.
- Latency: acceptance at edge E0 → out_valid_o rises after edge E0+NR, i.e. NR RUN cycles.
- DONE: ct_o and out_valid_o are held stable. On out_ready_i = 1, go to IDLE; out_valid_o is low the next cycle. No new plaintext is accepted in the handoff cycle.
- Upstream must hold the key/tweak feeding the key schedule stable from acceptance to DONE. tk_i is sampled only in RUN.
- CPU_RESET asserted in any state, including mid-RUN:
  - all registers clear immediately without waiting for a clock;
  - any in-flight encryption is discarded, and no partial ct_o is ever flagged valid;
  - the first edge after deassertion behaves as IDLE.
- out_ready_i is ignored outside DONE. in_valid_i is ignored outside IDLE.

Test Plan:
- Reset: assert CPU_RESET with no clock edge → in_ready_o = 1, out_valid_o = 0, ct_o = 0, round_o = 0 immediately.
- NR=1, tk_i = 0, pt = 0 → ct_o = 64'h0000_1100_0000_0000, out_valid_o 1 cycle after accept.
- NR=2, tk_i = 0, pt = 0:
  - round_o sequence is 0,1;
  - ct_o = 64'hCAAC_8400_CAAC_CCCC.
- NR=32 with craft_key_schedule attached:
  - K = 128'h27a6781a43f364bc916708d5fbb5aefe, T = 64'h54cd94ffd0670a58, pt = 64'h5734f006d8d88a3e;
  - ct_o equals the golden-model CRAFT ciphertext;
  - round_o steps 0..31 one per cycle;
  - out_valid_o rises exactly 32 edges after accept.
- Backpressure:
  - hold out_ready_i = 0 for 5 cycles in DONE with in_valid_i = 1 → ct_o stable, in_ready_o = 0, no new load;
  - raise out_ready_i → IDLE next cycle, and the following accept starts at round_o = 0.
- Reset mid-RUN: pulse CPU_RESET at round_o = 10 → round_o = 0 and in_ready_o = 1 immediately, out_valid_o never asserts for that block. A fresh NR=2 zero vector then yields 64'hCAAC_8400_CAAC_CCCC.

Source files
------------

// File: rtl/craft_round_core.sv
// rtl/craft_round_core.sv - iterative CRAFT-64 round datapath, one round per clock
//
// Purpose: encrypts one 64-bit block using round tweakeys supplied combinationally
// by an external key schedule. Plaintext enters through a valid/ready handshake and
// the ciphertext is held under valid/ready until the consumer takes it.
//
// Ports:
//   CLK100MHZ    in   1   clock
//   CPU_RESET    in   1   asynchronous active-high reset
//   pt_i         in  64   plaintext, nibble I0 = [63:60] ... I15 = [3:0]
//   in_valid_i   in   1   plaintext valid
//   in_ready_o   out  1   high only while idle
//   round_o      out  8   round index driven to the key schedule (0 outside RUN)
//   tk_i         in  64   round tweakey for round_o, used in the same cycle
//   ct_o         out 64   ciphertext
//   out_valid_o  out  1   high only while holding a finished ciphertext
//   out_ready_i  in   1   consumer accepts ct_o

module craft_round_core #(
    parameter int NR = 32
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESET,
    input  logic [63:0] pt_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [7:0]  round_o,
    input  logic [63:0] tk_i,
    output logic [63:0] ct_o,
    output logic        out_valid_o,
    input  logic        out_ready_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [7:0] LAST_RND = 8'(NR - 1);

    logic [1:0]  state;
    logic [63:0] s;
    logic [7:0]  rnd;
    logic [3:0]  a;
    logic [2:0]  b;

    logic [63:0] mc_s;
    logic [63:0] atk_s;
    logic [63:0] nxt_s;
    logic        last_rnd;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC;
            4'h1: sbox = 4'hA;
            4'h2: sbox = 4'hD;
            4'h3: sbox = 4'h3;
            4'h4: sbox = 4'hE;
            4'h5: sbox = 4'hB;
            4'h6: sbox = 4'hF;
            4'h7: sbox = 4'h7;
            4'h8: sbox = 4'h8;
            4'h9: sbox = 4'h9;
            4'hA: sbox = 4'h1;
            4'hB: sbox = 4'h5;
            4'hC: sbox = 4'h0;
            4'hD: sbox = 4'h2;
            4'hE: sbox = 4'h4;
            default: sbox = 4'h6;
        endcase
    endfunction

    // Destination nibble position for source nibble i under the permutation.
    function automatic int pn_pos(input int i);
        case (i)
            0:  pn_pos = 15;
            1:  pn_pos = 12;
            2:  pn_pos = 13;
            3:  pn_pos = 14;
            4:  pn_pos = 10;
            5:  pn_pos = 9;
            6:  pn_pos = 8;
            7:  pn_pos = 11;
            8:  pn_pos = 6;
            9:  pn_pos = 5;
            10: pn_pos = 4;
            11: pn_pos = 7;
            12: pn_pos = 1;
            13: pn_pos = 2;
            14: pn_pos = 3;
            default: pn_pos = 0;
        endcase
    endfunction

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);
    assign round_o     = (state == RUN) ? rnd : 8'd0;
    assign last_rnd    = (rnd == LAST_RND);

    // MixColumn reads only the registered state, so every right-hand side is pre-MC.
    always_comb begin
        mc_s = s;
        for (int c = 0; c < 4; c++) begin
            mc_s[63-4*c -: 4]     = s[63-4*c -: 4] ^ s[63-4*(c+8) -: 4] ^ s[63-4*(c+12) -: 4];
            mc_s[63-4*(c+4) -: 4] = s[63-4*(c+4) -: 4] ^ s[63-4*(c+12) -: 4];
        end
    end

    // Round constants land on I4 (a) and I5 (b), then the round tweakey.
    always_comb begin
        atk_s = mc_s ^ tk_i;
        atk_s[47:44] = atk_s[47:44] ^ a;
        atk_s[43:40] = atk_s[43:40] ^ {1'b0, b};
    end

    // PN and SB fused: each nibble is substituted on its way to its new slot.
    always_comb begin
        nxt_s = '0;
        for (int i = 0; i < 16; i++) begin
            nxt_s[63-4*pn_pos(i) -: 4] = sbox(atk_s[63-4*i -: 4]);
        end
    end

    always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
        if (CPU_RESET) begin
            state <= IDLE;
            s     <= '0;
            rnd   <= '0;
            a     <= 4'h1;
            b     <= 3'h1;
            ct_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        s     <= pt_i;
                        rnd   <= '0;
                        a     <= 4'h1;
                        b     <= 3'h1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (last_rnd) begin
                        // Final round stops after the tweakey addition.
                        ct_o  <= atk_s;
                        state <= DONE;
                    end else begin
                        s   <= nxt_s;
                        rnd <= rnd + 8'd1;
                        a   <= {a[0] ^ a[1], a[3:1]};
                        b   <= {b[0] ^ b[1], b[2:1]};
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_craft_round_core.sv
// tb/tb_craft_round_core.sv - self-checking bench for craft_round_core (NR = 1, 2, 32)

module tb_craft_round_core;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [2:0][63:0] pt;
    logic [2:0]       vin;
    logic [2:0]       ordy;
    logic [2:0]       inrdy;
    logic [2:0]       outv;
    logic [2:0][7:0]  round;
    logic [2:0][63:0] ct;

    logic [63:0] tk1;
    logic [63:0] tk2;
    logic [63:0] tk32;
    logic [63:0] tks2  [32];
    logic [63:0] tks32 [32];

    int checks = 0;
    int errors = 0;

    logic [3:0] SB_T [16] = '{4'hC, 4'hA, 4'hD, 4'h3, 4'hE, 4'hB, 4'hF, 4'h7,
                              4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6};
    int         P_T  [16] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
    int         Q_T  [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};
    logic [3:0] RCA  [15] = '{4'h1, 4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB,
                              4'h5, 4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3};
    logic [3:0] RCB  [7]  = '{4'h1, 4'h4, 4'h2, 4'h5, 4'h6, 4'h7, 4'h3};

    always #5 clk = ~clk;

    assign tk2  = tks2[round[1][4:0]];
    assign tk32 = tks32[round[2][4:0]];

    craft_round_core #(.NR(1)) u_nr1 (
        .CLK100MHZ(clk), .CPU_RESET(rst), .pt_i(pt[0]), .in_valid_i(vin[0]),
        .in_ready_o(inrdy[0]), .round_o(round[0]), .tk_i(tk1), .ct_o(ct[0]),
        .out_valid_o(outv[0]), .out_ready_i(ordy[0])
    );

    craft_round_core #(.NR(2)) u_nr2 (
        .CLK100MHZ(clk), .CPU_RESET(rst), .pt_i(pt[1]), .in_valid_i(vin[1]),
        .in_ready_o(inrdy[1]), .round_o(round[1]), .tk_i(tk2), .ct_o(ct[1]),
        .out_valid_o(outv[1]), .out_ready_i(ordy[1])
    );

    craft_round_core #(.NR(32)) u_nr32 (
        .CLK100MHZ(clk), .CPU_RESET(rst), .pt_i(pt[2]), .in_valid_i(vin[2]),
        .in_ready_o(inrdy[2]), .round_o(round[2]), .tk_i(tk32), .ct_o(ct[2]),
        .out_valid_o(outv[2]), .out_ready_i(ordy[2])
    );

    // Reference CRAFT: nibble arrays, table-driven constants, full rounds except the last.
    function automatic logic [63:0] craft_model(input logic [63:0] p,
                                                input logic [63:0] tkv [32],
                                                input int nr);
        logic [3:0]  s [16];
        logic [3:0]  t [16];
        logic [63:0] r64;
        for (int i = 0; i < 16; i++) s[i] = p[63-4*i -: 4];
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < 4; c++) begin
                t[c]      = s[c] ^ s[c+8] ^ s[c+12];
                t[c+4]    = s[c+4] ^ s[c+12];
                t[c+8]    = s[c+8];
                t[c+12]   = s[c+12];
            end
            t[4] = t[4] ^ RCA[r % 15];
            t[5] = t[5] ^ RCB[r % 7];
            for (int i = 0; i < 16; i++) t[i] = t[i] ^ tkv[r][63-4*i -: 4];
            if (r == nr - 1) begin
                s = t;
            end else begin
                for (int i = 0; i < 16; i++) s[P_T[i]] = SB_T[t[i]];
            end
        end
        for (int i = 0; i < 16; i++) r64[63-4*i -: 4] = s[i];
        return r64;
    endfunction

    task automatic set_tk32(input logic [127:0] k, input logic [63:0] tw);
        logic [63:0] qt;
        for (int i = 0; i < 16; i++) qt[63-4*i -: 4] = tw[63-4*Q_T[i] -: 4];
        for (int r = 0; r < 32; r++) begin
            case (r % 4)
                0: tks32[r] = k[127:64] ^ tw;
                1: tks32[r] = k[63:0] ^ tw;
                2: tks32[r] = k[127:64] ^ qt;
                default: tks32[r] = k[63:0] ^ qt;
            endcase
        end
    endtask

    // Pushes one block through instance u and records what it observed.
    task automatic drive_block(input int u, input logic [63:0] p, input int budget,
                               output logic [63:0] ct_seen, output int lat,
                               output int bad, output logic v_after, output logic r_after);
        @(negedge clk);
        pt[u] = p; vin[u] = 1'b1; ordy[u] = 1'b0;
        @(negedge clk);
        vin[u] = 1'b0; pt[u] = {$urandom, $urandom};
        lat = 0; bad = 0;
        while (outv[u] !== 1'b1 && lat < budget) begin
            if (round[u] !== lat[7:0]) bad++;
            if (inrdy[u] !== 1'b0) bad++;
            lat++;
            @(negedge clk);
        end
        ct_seen = ct[u];
        ordy[u] = 1'b1;
        @(negedge clk);
        ordy[u] = 1'b0;
        v_after = outv[u];
        r_after = inrdy[u];
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        for (int u = 0; u < 3; u++) begin
            checks++; if (inrdy[u] !== 1'b1) begin errors++; $display("FAIL reset_in_ready u%0d: got %b expected 1", u, inrdy[u]); end
            checks++; if (outv[u] !== 1'b0) begin errors++; $display("FAIL reset_out_valid u%0d: got %b expected 0", u, outv[u]); end
            checks++; if (ct[u] !== 64'h0) begin errors++; $display("FAIL reset_ct u%0d: got %h expected 0", u, ct[u]); end
            checks++; if (round[u] !== 8'h0) begin errors++; $display("FAIL reset_round u%0d: got %h expected 0", u, round[u]); end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_nr1_zero;
        logic [63:0] c; int lat; int bad; logic va; logic ra;
        tk1 = 64'h0;
        drive_block(0, 64'h0, 8, c, lat, bad, va, ra);
        checks++; if (c !== 64'h0000_1100_0000_0000) begin errors++; $display("FAIL nr1_ct: got %h expected 0000110000000000", c); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL nr1_latency: got %0d expected 1", lat); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL nr1_run_outputs: got %0d bad cycles expected 0", bad); end
        checks++; if (va !== 1'b0 || ra !== 1'b1) begin errors++; $display("FAIL nr1_handoff: got valid %b ready %b expected 0 1", va, ra); end
    endtask

    task automatic test_nr2_zero(input string tag);
        logic [63:0] c; int lat; int bad; logic va; logic ra;
        for (int r = 0; r < 32; r++) tks2[r] = 64'h0;
        drive_block(1, 64'h0, 8, c, lat, bad, va, ra);
        checks++; if (c !== 64'hCAAC_8400_CAAC_CCCC) begin errors++; $display("FAIL %s_ct: got %h expected caac8400caaccccc", tag, c); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL %s_latency: got %0d expected 2", tag, lat); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL %s_round_seq: got %0d bad cycles expected 0", tag, bad); end
        checks++; if (va !== 1'b0 || ra !== 1'b1) begin errors++; $display("FAIL %s_handoff: got valid %b ready %b expected 0 1", tag, va, ra); end
    endtask

    task automatic test_nr32(input logic [127:0] k, input logic [63:0] tw, input logic [63:0] p, input string tag);
        logic [63:0] c; logic [63:0] e; int lat; int bad; logic va; logic ra;
        set_tk32(k, tw);
        e = craft_model(p, tks32, 32);
        drive_block(2, p, 40, c, lat, bad, va, ra);
        checks++; if (c !== e) begin errors++; $display("FAIL %s_ct: got %h expected %h", tag, c, e); end
        checks++; if (lat !== 32) begin errors++; $display("FAIL %s_latency: got %0d expected 32", tag, lat); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL %s_round_seq: got %0d bad cycles expected 0", tag, bad); end
        checks++; if (va !== 1'b0 || ra !== 1'b1) begin errors++; $display("FAIL %s_handoff: got valid %b ready %b expected 0 1", tag, va, ra); end
    endtask

    task automatic test_random_nr2;
        logic [63:0] c; logic [63:0] e; logic [63:0] p; int lat; int bad; logic va; logic ra;
        for (int n = 0; n < 8; n++) begin
            for (int r = 0; r < 32; r++) tks2[r] = {$urandom, $urandom};
            p = {$urandom, $urandom};
            e = craft_model(p, tks2, 2);
            drive_block(1, p, 8, c, lat, bad, va, ra);
            checks++; if (c !== e) begin errors++; $display("FAIL rand_nr2_ct[%0d]: got %h expected %h", n, c, e); end
            checks++; if (lat !== 2 || bad !== 0) begin errors++; $display("FAIL rand_nr2_timing[%0d]: got lat %0d bad %0d expected 2 0", n, lat, bad); end
        end
    endtask

    task automatic test_random_nr32;
        for (int n = 0; n < 3; n++) begin
            test_nr32({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom},
                      {$urandom, $urandom}, "rand_nr32");
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] p1; logic [63:0] p2; logic [63:0] c0; logic [63:0] e1; logic [63:0] e2;
        int wait_cyc;
        for (int r = 0; r < 32; r++) tks2[r] = {$urandom, $urandom};
        p1 = {$urandom, $urandom};
        p2 = {$urandom, $urandom};
        e1 = craft_model(p1, tks2, 2);
        e2 = craft_model(p2, tks2, 2);
        @(negedge clk);
        pt[1] = p1; vin[1] = 1'b1; ordy[1] = 1'b0;
        @(negedge clk);
        vin[1] = 1'b0;
        wait_cyc = 0;
        while (outv[1] !== 1'b1 && wait_cyc < 10) begin wait_cyc++; @(negedge clk); end
        checks++; if (outv[1] !== 1'b1) begin errors++; $display("FAIL bp_done_timeout: got valid %b expected 1", outv[1]); end
        c0 = ct[1];
        checks++; if (c0 !== e1) begin errors++; $display("FAIL bp_ct_first: got %h expected %h", c0, e1); end
        pt[1] = p2; vin[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (ct[1] !== e1) begin errors++; $display("FAIL bp_ct_hold[%0d]: got %h expected %h", i, ct[1], e1); end
            checks++; if (inrdy[1] !== 1'b0 || outv[1] !== 1'b1) begin errors++; $display("FAIL bp_flags[%0d]: got ready %b valid %b expected 0 1", i, inrdy[1], outv[1]); end
        end
        ordy[1] = 1'b1;
        @(negedge clk);
        ordy[1] = 1'b0;
        checks++; if (outv[1] !== 1'b0 || inrdy[1] !== 1'b1) begin errors++; $display("FAIL bp_handoff: got valid %b ready %b expected 0 1", outv[1], inrdy[1]); end
        @(negedge clk);
        vin[1] = 1'b0;
        checks++; if (round[1] !== 8'd0 || inrdy[1] !== 1'b0) begin errors++; $display("FAIL bp_reaccept: got round %0d ready %b expected 0 0", round[1], inrdy[1]); end
        @(negedge clk);
        checks++; if (round[1] !== 8'd1) begin errors++; $display("FAIL bp_round1: got %0d expected 1", round[1]); end
        @(negedge clk);
        checks++; if (outv[1] !== 1'b1 || ct[1] !== e2) begin errors++; $display("FAIL bp_ct_second: got valid %b ct %h expected 1 %h", outv[1], ct[1], e2); end
        ordy[1] = 1'b1;
        @(negedge clk);
        ordy[1] = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        int wait_cyc; int seen;
        set_tk32(128'h27a6781a43f364bc916708d5fbb5aefe, 64'h54cd94ffd0670a58);
        @(negedge clk);
        pt[2] = 64'h5734f006d8d88a3e; vin[2] = 1'b1; ordy[2] = 1'b0;
        @(negedge clk);
        vin[2] = 1'b0;
        wait_cyc = 0;
        while (round[2] !== 8'd10 && wait_cyc < 40) begin wait_cyc++; @(negedge clk); end
        checks++; if (round[2] !== 8'd10) begin errors++; $display("FAIL midrst_reach10: got %0d expected 10", round[2]); end
        #1 rst = 1'b1;
        #1;
        checks++; if (round[2] !== 8'd0) begin errors++; $display("FAIL midrst_round: got %0d expected 0", round[2]); end
        checks++; if (inrdy[2] !== 1'b1 || outv[2] !== 1'b0) begin errors++; $display("FAIL midrst_flags: got ready %b valid %b expected 1 0", inrdy[2], outv[2]); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (outv[2] !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_valid: got %0d valid cycles expected 0", seen); end
        test_nr2_zero("midrst_nr2");
    endtask

    initial begin
        pt = '0; vin = '0; ordy = '0; tk1 = '0;
        for (int r = 0; r < 32; r++) begin tks2[r] = '0; tks32[r] = '0; end
        test_reset;
        test_nr1_zero;
        test_nr2_zero("nr2_zero");
        test_nr32(128'h27a6781a43f364bc916708d5fbb5aefe, 64'h54cd94ffd0670a58,
                  64'h5734f006d8d88a3e, "nr32_vector");
        test_random_nr2;
        test_random_nr32;
        test_back_to_back;
        test_reset_mid_run;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
